avalon_reg_arbiter: RTL and testbench
=====================================

// Module: avalon_reg_arbiter
// PURPOSE
//   Shares one 3-register Avalon-MM slave (chipselect/read/write, 1-cycle registered readdata)
//   between two requesters: the Nios bus bridge (req0) and a hardware engine (req1).
//   Round-robin arbitration, one transaction in flight, read-latency handling and
//   out-of-range address rejection. Sits between the requesters and the slave in the peripheral.
// PARAMETERS
//   DATA_W    32  data width of requester and slave buses
//   ADDR_W    2   register address width
//   NUM_REGS  3   implemented registers; addr >= NUM_REGS is rejected
//   RD_LAT    1   slave read latency in cycles, >= 1
// PORTS
//   clk          in   1       clock, all logic on rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   req0/req1    in   1       request; held high until own ack
//   we0/we1      in   1       1 = write, 0 = read; stable while req high
//   addr0/addr1  in   ADDR_W  register address; stable while req high
//   wdata0/wdata1 in  DATA_W  write data; stable while req high
//   ack0/ack1    out  1       one-cycle completion pulse to the owning requester
//   rdata        out  DATA_W  read result; valid in the ack cycle (shared by both requesters)
//   err          out  1       valid in the ack cycle; 1 = address out of range
//   busy         out  1       1 whenever the FSM is not IDLE
//   av_chipselect out 1       to slave
//   av_read       out 1       to slave
//   av_write      out 1       to slave
//   av_address    out ADDR_W  to slave
//   av_writedata  out DATA_W  to slave
//   av_readdata   in  DATA_W  from slave
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, rr pointer = 0 (req0 favoured), winner regs cleared.
//     Asserting reset mid-transaction aborts it with no ack; the slave sees no further strobes.
//   FSM states: IDLE, ISSUE, WAIT, ACK.
//   - IDLE: if neither req, stay. If only one req, it wins. If both, the rr pointer
//       requester wins. Latch winner id, we, addr, wdata. If addr >= NUM_REGS, go to ACK
//       with err=1 and rdata=0 (no bus cycle). Otherwise go to ISSUE.
//   - ISSUE (exactly 1 cycle): av_chipselect=1, av_address/av_writedata from the latched
//       values; av_write=we, av_read=~we. Never both strobes. A write goes to ACK.
//       A read goes to WAIT with the latency counter loaded to RD_LAT.
//   - WAIT: all strobes 0. Decrement the counter each cycle. In the last cycle
//       (counter==1), capture av_readdata into rdata and go to ACK.
//   - ACK (1 cycle): ack of the winner = 1; err valid. rr pointer <- other requester. Go to IDLE.
//   Latency (req seen in IDLE at cycle 0):
//     - Write: strobe in cycle 1, ack in cycle 2.
//     - Read: strobe in cycle 1, ack in cycle 2+RD_LAT.
//     - Rejected address: ack in cycle 1.
//   A requester holding req through its ack is re-arbitrated in the next IDLE cycle. It loses
//     to the other requester if both are pending (the pointer has moved). Minimum gap between
//     transactions is the IDLE cycle.
//   A req dropped before ack: the latched transaction completes and the ack still pulses.
//   Requester inputs are sampled only in IDLE; changes during a transaction are ignored.
//   rdata holds its last value outside the ack cycle. rdata is unchanged for write acks.
//   err = 0 on every in-range ack.
//   av_* address/data outputs may hold stale values when strobes are 0.
//   The slave sees at most one strobe per transaction.
// STRUCTURE
//   Package avalon_arb_pkg:
//     - state enum {IDLE, ISSUE, WAIT, ACK}
//     - requester-id constants REQ0=0, REQ1=1
//     - latency counter width function clog2(RD_LAT+1)
//   Sub-module rr_arb2: req0/req1 + pointer -> one-hot grant; pointer updated on an ack
//     strobe input. Reused by later shared-resource controllers in this peripheral.
//   Top: FSM, latch registers, latency counter, output registers.
// TESTING
//   Bench pairs the arbiter with a behavioural 3-register slave model (RD_LAT=1).
//   1 Reset, req0 write addr=1 data=0xDEADBEEF -> av_write=1 in cycle 1 only; ack0 in cycle 2;
//     a later req1 read addr=1 -> ack1 at read latency with rdata=0xDEADBEEF, err=0.
//   2 req0 and req1 both high from reset (req0 read addr0, req1 read addr2) -> ack0 first,
//     then ack1. Keep both high -> grants strictly alternate 0,1,0,1 over 8 transactions.
//   3 req1 read addr=3 -> no av_chipselect; ack1 in cycle 1 with err=1, rdata=0.
//     The next in-range ack has err=0.
//   4 Reset pulse during WAIT of a read -> no ack; all outputs 0; rr pointer=0.
//     A following req0 write completes normally.
//   5 req0 drops one cycle after acceptance, with addr0 changed -> the original
//     address/data reach the slave; ack0 still pulses.
//   6 RD_LAT=3 build: read from addr 2 -> ack in cycle 5; rdata = the slave value.
//     Strobes are 0 during all WAIT cycles.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon register arbiter and its round-robin core.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Counter must be able to hold RD_LAT itself; degenerate latencies still get one bit.
    function automatic int lat_cnt_width(input int rd_lat);
        return (rd_lat < 1) ? 1 : $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two requests; the pointer moves
// to the other requester whenever a completion strobe is seen.
module rr_arb2
    import avalon_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       ack_strobe,
    input  logic       ack_id,
    output logic [1:0] grant
);

    logic pointer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= REQ0;
        end else if (ack_strobe) begin
            pointer <= ~ack_id;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = (pointer == REQ0) ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/avalon_reg_arbiter.sv
// Shares one small Avalon-MM register slave between two requesters with round-robin
// arbitration, a single transaction in flight and out-of-range address rejection.
module avalon_reg_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 3,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              av_chipselect,
    output logic              av_read,
    output logic              av_write,
    output logic [ADDR_W-1:0] av_address,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata
);

    localparam int CNT_W = lat_cnt_width(RD_LAT);

    arb_state_t state;
    arb_state_t next_state;

    logic [1:0]        grant;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    logic              win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  lat_cnt;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .ack_strobe (state == ACK),
        .ack_id     (win_id),
        .grant      (grant)
    );

    // Requester inputs only matter in IDLE; afterwards everything runs off the latched copy.
    assign accept    = (state == IDLE) && (grant != 2'b00);
    assign sel_we    = grant[1] ? we1    : we0;
    assign sel_addr  = grant[1] ? addr1  : addr0;
    assign sel_wdata = grant[1] ? wdata1 : wdata0;
    assign sel_bad   = (int'(sel_addr) >= NUM_REGS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = sel_bad ? ACK : ISSUE;
                end
            end
            ISSUE:   next_state = win_we ? ACK : WAIT;
            WAIT: begin
                if (lat_cnt == CNT_W'(1)) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A rejected request zeroes rdata up front, since it skips WAIT and goes straight to ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_id    <= REQ0;
            win_we    <= 1'b0;
            win_addr  <= '0;
            win_wdata <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            lat_cnt   <= '0;
        end else begin
            if (accept) begin
                win_id    <= grant[1] ? REQ1 : REQ0;
                win_we    <= sel_we;
                win_addr  <= sel_addr;
                win_wdata <= sel_wdata;
                err_q     <= sel_bad;
                if (sel_bad) begin
                    rdata_q <= '0;
                end
            end
            if (state == ISSUE && !win_we) begin
                lat_cnt <= CNT_W'(RD_LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    rdata_q <= av_readdata;
                end
            end
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        av_chipselect = (state == ISSUE);
        av_write      = (state == ISSUE) && win_we;
        av_read       = (state == ISSUE) && !win_we;
        av_address    = win_addr;
        av_writedata  = win_wdata;
        ack0          = (state == ACK) && (win_id == REQ0);
        ack1          = (state == ACK) && (win_id == REQ1);
        err           = (state == ACK) && err_q;
        rdata         = rdata_q;
    end

endmodule

// File: tb/tb_avalon_reg_arbiter.sv
// Bench: arbiter with behavioural register slaves (RD_LAT=1 and RD_LAT=3 instances),
// scoreboard of expected completions checked on every ack.
module tb_avalon_reg_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [1:0]  addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err, busy, av_chipselect, av_read, av_write;
    logic [31:0] rdata, av_writedata, av_readdata = 0;
    logic [1:0]  av_address;

    logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
    logic [1:0]  b_addr0 = 0, b_addr1 = 0;
    logic [31:0] b_wdata0 = 0, b_wdata1 = 0;
    logic        b_ack0, b_ack1, b_err, b_busy, b_av_chipselect, b_av_read, b_av_write;
    logic [31:0] b_rdata, b_av_writedata, b_av_readdata = 0;
    logic [1:0]  b_av_address;

    avalon_reg_arbiter #(.DATA_W(32), .ADDR_W(2), .NUM_REGS(3), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .av_chipselect(av_chipselect), .av_read(av_read), .av_write(av_write),
        .av_address(av_address), .av_writedata(av_writedata), .av_readdata(av_readdata)
    );

    avalon_reg_arbiter #(.DATA_W(32), .ADDR_W(2), .NUM_REGS(3), .RD_LAT(3)) dut_lat3 (
        .clk(clk), .reset_n(reset_n),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .err(b_err), .busy(b_busy),
        .av_chipselect(b_av_chipselect), .av_read(b_av_read), .av_write(b_av_write),
        .av_address(b_av_address), .av_writedata(b_av_writedata), .av_readdata(b_av_readdata)
    );

    // Behavioural slaves: three registers, readdata registered one cycle after the read strobe.
    logic [31:0] slave_a [0:2] = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002};
    logic [31:0] slave_b [0:2] = '{32'hB0B0_0000, 32'hB0B0_0001, 32'hB0B0_0002};

    always @(posedge clk) begin
        if (av_chipselect && av_write && av_address < 2'd3) slave_a[av_address] <= av_writedata;
        if (av_chipselect && av_read && av_address < 2'd3) av_readdata <= slave_a[av_address];
        if (b_av_chipselect && b_av_write && b_av_address < 2'd3) slave_b[b_av_address] <= b_av_writedata;
        if (b_av_chipselect && b_av_read && b_av_address < 2'd3) b_av_readdata <= slave_b[b_av_address];
    end

    typedef struct {
        logic        id;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [0:2] = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002};
    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    logic [31:0] last_rdata = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic id, input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.id = id; e.we = we; e.addr = addr; e.wdata = wdata;
        e.err = (addr >= 2'd3);
        e.rdata = 32'h0;
        if (!e.err && !we) e.rdata = shadow[addr];
        if (!e.err && we) shadow[addr] = wdata;
        exp_q.push_back(e);
    endtask

    task automatic driveReq(input logic id, input logic req, input logic we, input logic [1:0] addr,
                            input logic [31:0] wdata);
        if (id) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    // Scoreboard monitor: strobe contents against the front entry, completions popped on ack.
    always @(negedge clk) begin
        if (!reset_n) begin
            strobe_cnt = 0;
            last_rdata = 32'h0;
        end else begin
            if (av_read && av_write) checkOutput("both_strobes", 1, 0);
            if (av_chipselect) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("strobe_unexpected", 1, 0);
                end else begin
                    checkOutput("av_address", av_address, exp_q[0].addr);
                    checkOutput("av_write", av_write, exp_q[0].we);
                    if (exp_q[0].we) checkOutput("av_writedata", av_writedata, exp_q[0].wdata);
                end
            end
            if (ack0 || ack1) begin
                checkOutput("ack_exclusive", ack0 && ack1, 0);
                if (exp_q.size() == 0) begin
                    checkOutput("ack_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("ack_id", ack1, e.id);
                    checkOutput("err", err, e.err);
                    checkOutput("strobe_count", strobe_cnt, e.err ? 0 : 1);
                    if (e.we && !e.err) begin
                        checkOutput("rdata_hold", rdata, last_rdata);
                    end else begin
                        checkOutput("rdata", rdata, e.rdata);
                        last_rdata = e.rdata;
                    end
                end
                strobe_cnt = 0;
            end
        end
    end

    // Lone transaction on the RD_LAT=1 instance, with exact strobe and ack cycle checks.
    task automatic applyStimulus(input logic id, input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        bit done;
        bit bad;
        int exp_lat;
        bad = (addr >= 2'd3);
        exp_lat = bad ? 1 : (we ? 2 : 3);
        pushExp(id, we, addr, wdata);
        @(posedge clk);
        #1;
        driveReq(id, 1'b1, we, addr, wdata);
        done = 0;
        for (int c = 0; c <= 10 && !done; c++) begin
            @(negedge clk);
            checkOutput("cs_timing", av_chipselect, (!bad && c == 1));
            if ((id ? ack1 : ack0) === 1'b1) begin
                checkOutput("ack_latency", c, exp_lat);
                driveReq(id, 1'b0, we, addr, wdata);
                done = 1;
            end
        end
        if (!done) begin
            checkOutput("ack_timeout", 0, 1);
            driveReq(id, 1'b0, we, addr, wdata);
        end
    endtask

    // Holds a request high across n of its own acks, then drops it in the last ack cycle.
    task automatic holdRequest(input logic id, input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                               input int n);
        int got;
        got = 0;
        @(posedge clk);
        #1;
        driveReq(id, 1'b1, we, addr, wdata);
        for (int c = 0; c < 300 && got < n; c++) begin
            @(negedge clk);
            if ((id ? ack1 : ack0) === 1'b1) got++;
        end
        driveReq(id, 1'b0, we, addr, wdata);
        checkOutput("hold_ack_count", got, n);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("reset_ctrl", {busy, ack0, ack1, err, av_chipselect, av_read, av_write}, 0);
        checkOutput("reset_rdata", rdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        doReset();
        checkOutput("reset_addr", av_address, 0);
        checkOutput("reset_wdata", av_writedata, 0);

        $display("[TB] write then read back across requesters");
        applyStimulus(1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);

        $display("[TB] both requesters held: strict alternation");
        doReset();
        for (int k = 0; k < 4; k++) begin
            pushExp(1'b0, 1'b0, 2'd0, 32'h0);
            pushExp(1'b1, 1'b0, 2'd2, 32'h0);
        end
        fork
            holdRequest(1'b0, 1'b0, 2'd0, 32'h0, 4);
            holdRequest(1'b1, 1'b0, 2'd2, 32'h0, 4);
        join

        $display("[TB] out-of-range address");
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h1234_5678);

        $display("[TB] reset during read wait");
        pushExp(1'b0, 1'b0, 2'd0, 32'h0);
        @(posedge clk);
        #1;
        driveReq(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        exp_q.delete();
        #1;
        checkOutput("abort_ctrl", {busy, ack0, ack1, err, av_chipselect, av_read, av_write}, 0);
        checkOutput("abort_rdata", rdata, 0);
        checkOutput("abort_addr", av_address, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("abort_no_ack", {ack0, ack1, busy}, 0);
        end
        pushExp(1'b0, 1'b1, 2'd2, 32'hCAFE_0002);
        pushExp(1'b1, 1'b0, 2'd2, 32'h0);
        fork
            holdRequest(1'b0, 1'b1, 2'd2, 32'hCAFE_0002, 1);
            holdRequest(1'b1, 1'b0, 2'd2, 32'h0, 1);
        join

        $display("[TB] requester drops and changes inputs after acceptance");
        pushExp(1'b0, 1'b1, 2'd1, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        driveReq(1'b0, 1'b1, 1'b1, 2'd1, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        driveReq(1'b0, 1'b0, 1'b1, 2'd2, 32'hBAD0_BAD0);
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(negedge clk);
                if (ack0 === 1'b1) seen = 1;
            end
            checkOutput("drop_ack_seen", seen, 1);
        end
        applyStimulus(1'b0, 1'b0, 2'd1, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0);

        $display("[TB] RD_LAT=3 instance read");
        begin
            bit done;
            done = 0;
            @(posedge clk);
            #1;
            b_we0 = 1'b0;
            b_addr0 = 2'd2;
            b_req0 = 1'b1;
            for (int c = 0; c <= 12 && !done; c++) begin
                @(negedge clk);
                checkOutput("lat3_strobes", {b_av_chipselect, b_av_read, b_av_write}, (c == 1) ? 3'b110 : 3'b000);
                if (b_ack0 === 1'b1) begin
                    checkOutput("lat3_ack_latency", c, 5);
                    checkOutput("lat3_rdata", b_rdata, 32'hB0B0_0002);
                    checkOutput("lat3_err", b_err, 0);
                    b_req0 = 1'b0;
                    done = 1;
                end
            end
            if (!done) begin
                checkOutput("lat3_ack_timeout", 0, 1);
                b_req0 = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
